// File: rtl/i2c_codec_responder_pkg.sv
// Shared types and constants for the codec control-port I2C responder.
// Register power-on values mirror the codec's documented reset state.
package codec_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_ADDR,
        S_ACK_A,
        S_BYTE1,
        S_ACK1,
        S_BYTE2,
        S_ACK2,
        S_EXTRA,
        S_IGNORE
    } I2cRespState;

    localparam logic [6:0] CODEC_DEV_ADDR = 7'h1A;
    localparam logic [6:0] CODEC_RST_REG  = 7'h0F;
    localparam int         CODEC_NREG     = 10;

    localparam logic [8:0] REG_DEFAULT [0:9] = '{
        9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
        9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
    };

    // Indices beyond the codec's register map default to zero.
    function automatic logic [8:0] reg_default(input int idx);
        logic [3:0] i4;
        i4 = idx[3:0];
        if (idx >= 0 && idx < CODEC_NREG) begin
            return REG_DEFAULT[i4];
        end
        return 9'h000;
    endfunction

endpackage

// File: rtl/i2c_codec_responder_if.sv
// Bus-side and register-side signals of the codec I2C responder.
// slave = responder view, master = bus model / observer view.
interface i2c_codec_responder_if #(
    parameter int NREG = 10
);
    logic              i_scl;
    logic              i_sda;
    logic              o_sda_oe;
    logic [NREG*9-1:0] o_regs;
    logic              o_wr_valid;
    logic [6:0]        o_wr_addr;
    logic [8:0]        o_wr_data;
    logic              o_soft_rst;
    logic              o_busy;

    modport slave (
        input  i_scl, i_sda,
        output o_sda_oe, o_regs, o_wr_valid, o_wr_addr, o_wr_data, o_soft_rst, o_busy
    );

    modport master (
        output i_scl, i_sda,
        input  o_sda_oe, o_regs, o_wr_valid, o_wr_addr, o_wr_data, o_soft_rst, o_busy
    );
endinterface

// File: rtl/i2c_codec_responder_line_cond.sv
// Conditions one async I2C line: 2-flop synchronizer, optional 3-sample
// majority filter (I2C_GLITCH_FILTER_EN), and rise/fall strobes.
module i2c_line_cond (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_line,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);
    logic [1:0] sync_q;
    logic       level;
    logic       prev_q;

    // Lines idle high, so reset to 1 to avoid a phantom edge after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_line};
        end
    end

`ifdef I2C_GLITCH_FILTER_EN
    logic [1:0] hist_q;
    logic       filt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hist_q <= 2'b11;
            filt_q <= 1'b1;
        end else begin
            hist_q <= {hist_q[0], sync_q[1]};
            filt_q <= (sync_q[1] & hist_q[0]) | (sync_q[1] & hist_q[1]) | (hist_q[0] & hist_q[1]);
        end
    end

    assign level = filt_q;
`else
    assign level = sync_q[1];
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level;
        end
    end

    assign o_level = level;
    assign o_rise  = level & ~prev_q;
    assign o_fall  = ~level & prev_q;
endmodule

// File: rtl/i2c_codec_responder.sv
// Write-only I2C target emulating the audio codec control port (16-bit writes
// into a 9-bit shadow register file). Optional: I2C_GLITCH_FILTER_EN.
module i2c_codec_responder
    import codec_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = CODEC_DEV_ADDR,
    parameter int         NREG     = CODEC_NREG,
    parameter logic [6:0] RST_REG  = CODEC_RST_REG
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    i2c_codec_responder_if.slave  bus
);
    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;

    i2c_line_cond u_scl (
        .i_clk (i_clk), .i_rst (i_rst), .i_line (bus.i_scl),
        .o_level (scl_lvl), .o_rise (scl_rise), .o_fall (scl_fall)
    );

    i2c_line_cond u_sda (
        .i_clk (i_clk), .i_rst (i_rst), .i_line (bus.i_sda),
        .o_level (sda_lvl), .o_rise (sda_rise), .o_fall (sda_fall)
    );

    logic start, stop, scl_up, scl_dn;
    assign start  = sda_fall & scl_lvl;
    assign stop   = sda_rise & scl_lvl;
    assign scl_up = scl_rise & ~start & ~stop;
    assign scl_dn = scl_fall;

    I2cRespState state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  byte1_q, byte1_d;
    logic        oe_q, oe_d;
    logic        commit;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            shift_q <= 8'h00;
            byte1_q <= 8'h00;
            oe_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            byte1_q <= byte1_d;
            oe_q    <= oe_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        byte1_d = byte1_q;
        oe_d    = oe_q;
        commit  = 1'b0;
        if (stop) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else if (start) begin
            state_d = S_ADDR;
            cnt_d   = 4'd0;
            oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_BYTE1, S_BYTE2: begin
                    if (scl_up && cnt_q != 4'd8) begin
                        shift_d = {shift_q[6:0], sda_lvl};
                        cnt_d   = cnt_q + 4'd1;
                    end else if (scl_dn && cnt_q == 4'd8) begin
                        // Byte complete: the fall ending bit 8 starts the ACK slot.
                        cnt_d = 4'd0;
                        if (state_q == S_ADDR) begin
                            if (shift_q[7:1] == DEV_ADDR && !shift_q[0]) begin
                                state_d = S_ACK_A;
                                oe_d    = 1'b1;
                            end else begin
                                state_d = S_IGNORE;
                            end
                        end else if (state_q == S_BYTE1) begin
                            byte1_d = shift_q;
                            state_d = S_ACK1;
                            oe_d    = 1'b1;
                        end else begin
                            state_d = S_ACK2;
                            oe_d    = 1'b1;
                        end
                    end
                end
                S_ACK_A, S_ACK1, S_ACK2: begin
                    if (scl_up && state_q == S_ACK2) begin
                        commit = 1'b1;
                    end
                    if (scl_dn) begin
                        oe_d = 1'b0;
                        case (state_q)
                            S_ACK_A: state_d = S_BYTE1;
                            S_ACK1:  state_d = S_BYTE2;
                            default: state_d = S_EXTRA;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte2 is still in the shift register during the ACK2 slot.
    logic [6:0] wr_idx;
    logic [8:0] wr_data;
    logic       is_rst_reg;
    assign wr_idx     = byte1_q[7:1];
    assign wr_data    = {byte1_q[0], shift_q};
    assign is_rst_reg = (wr_idx == RST_REG);

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_reg
            logic [8:0] reg_q;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    reg_q <= reg_default(gi);
                end else if (commit && is_rst_reg) begin
                    reg_q <= reg_default(gi);
                end else if (commit && wr_idx == 7'(gi)) begin
                    reg_q <= wr_data;
                end
            end
            assign bus.o_regs[9*gi +: 9] = reg_q;
        end
    endgenerate

    logic       wr_valid_q, soft_rst_q;
    logic [6:0] wr_addr_q;
    logic [8:0] wr_data_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_valid_q <= 1'b0;
            soft_rst_q <= 1'b0;
            wr_addr_q  <= 7'd0;
            wr_data_q  <= 9'd0;
        end else begin
            wr_valid_q <= commit;
            soft_rst_q <= commit & is_rst_reg;
            if (commit) begin
                wr_addr_q <= wr_idx;
                wr_data_q <= wr_data;
            end
        end
    end

    assign bus.o_sda_oe   = oe_q;
    assign bus.o_wr_valid = wr_valid_q;
    assign bus.o_wr_addr  = wr_addr_q;
    assign bus.o_wr_data  = wr_data_q;
    assign bus.o_soft_rst = soft_rst_q;
    assign bus.o_busy     = (state_q != S_IDLE);
endmodule

// File: tb/tb_i2c_codec_responder.sv
// Scoreboard bench for i2c_codec_responder: open-drain bus model drives
// directed writes; a negedge monitor checks every committed write.
module tb_i2c_codec_responder;
    // Clocks per quarter SCL period; SCL runs at 1/64 of i_clk.
    localparam int Q = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;

    i2c_codec_responder_if #(.NREG(10)) bus();

    // Pull-up bus: line is low if either side pulls it.
    assign bus.i_scl = scl_m;
    assign bus.i_sda = sda_m & ~bus.o_sda_oe;

    i2c_codec_responder #(.NREG(10)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #10ns clk = ~clk;

    typedef struct packed {
        logic [6:0] a;
        logic [8:0] d;
        logic       s;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [8:0] exp_regs [10];
    localparam logic [8:0] DEF [10] = '{
        9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
        9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000
    };

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int k = 0; k < 10; k++) begin
            check($sformatf("%s reg%0d", tag, k), 32'(bus.o_regs[9*k +: 9]), 32'(exp_regs[k]));
        end
    endtask

    task automatic defaults_to_model();
        for (int k = 0; k < 10; k++) exp_regs[k] = DEF[k];
    endtask

    task automatic qwait();
        repeat (Q) @(negedge clk);
    endtask

    task automatic start_cond();
        if (!scl_m) begin
            qwait(); sda_m = 1'b1;
            qwait(); scl_m = 1'b1;
        end
        qwait(); sda_m = 1'b0;
        qwait(); scl_m = 1'b0;
    endtask

    task automatic stop_cond();
        qwait(); sda_m = 1'b0;
        qwait(); scl_m = 1'b1;
        qwait(); sda_m = 1'b1;
        qwait();
    endtask

    task automatic send_bit(input logic b, output logic r);
        qwait(); sda_m = b;
        qwait(); scl_m = 1'b1;
        qwait(); r = bus.i_sda;
        qwait(); scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) send_bit(v[i], r);
        send_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic xfer3(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic exp_ack);
        logic ack;
        start_cond();
        write_byte(b0, ack); check({tag, " ack_addr"}, 32'(ack), 32'(exp_ack));
        write_byte(b1, ack); check({tag, " ack_b1"}, 32'(ack), 32'(exp_ack));
        write_byte(b2, ack); check({tag, " ack_b2"}, 32'(ack), 32'(exp_ack));
        stop_cond();
        check({tag, " busy_after_stop"}, 32'(bus.o_busy), 32'd0);
    endtask

    // Monitor: every o_wr_valid pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && bus.o_wr_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr=%0h data=%0h, required no write",
                         bus.o_wr_addr, bus.o_wr_data);
            end else begin
                mon_e = exp_q.pop_front();
                $display("write addr=%02h data=%03h soft_rst=%0b",
                         bus.o_wr_addr, bus.o_wr_data, bus.o_soft_rst);
                check("wr_addr", 32'(bus.o_wr_addr), 32'(mon_e.a));
                check("wr_data", 32'(bus.o_wr_data), 32'(mon_e.d));
                check("soft_rst", 32'(bus.o_soft_rst), 32'(mon_e.s));
            end
        end else if (!rst && bus.o_soft_rst) begin
            n_checks++;
            n_fail++;
            $display("FAIL lone_soft_rst: got soft_rst=1 without wr_valid, required 0");
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack, r, saw_busy, exp_busy;
        defaults_to_model();

        // Reset state
        repeat (5) @(negedge clk);
        check("rst sda_oe", 32'(bus.o_sda_oe), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("rst wr_valid", 32'(bus.o_wr_valid), 32'd0);
        check("rst soft_rst", 32'(bus.o_soft_rst), 32'd0);
        check("rst busy", 32'(bus.o_busy), 32'd0);
        check("rst wr_addr", 32'(bus.o_wr_addr), 32'd0);
        check("rst wr_data", 32'(bus.o_wr_data), 32'd0);
        check_regs("rst");

        // 1: reg4 <= 0x015
        exp_q.push_back('{a: 7'd4, d: 9'h015, s: 1'b0});
        exp_regs[4] = 9'h015;
        xfer3("t1", 8'h34, 8'h08, 8'h15, 1'b1);
        check_regs("t1");

        // 2: wrong address is ignored entirely
        xfer3("t2", 8'h36, 8'h08, 8'h15, 1'b0);
        check_regs("t2");

        // 3: reg2 <= 0x1FF, then soft reset via register 0x0F
        exp_q.push_back('{a: 7'd2, d: 9'h1FF, s: 1'b0});
        exp_regs[2] = 9'h1FF;
        xfer3("t3a", 8'h34, 8'h05, 8'hFF, 1'b1);
        check_regs("t3a");
        exp_q.push_back('{a: 7'h0F, d: 9'h000, s: 1'b1});
        defaults_to_model();
        xfer3("t3b", 8'h34, 8'h1E, 8'h00, 1'b1);
        check_regs("t3b");

        // 4: repeated START discards the half-written reg4 access
        start_cond();
        write_byte(8'h34, ack); check("t4 ack_addr", 32'(ack), 32'd1);
        write_byte(8'h08, ack); check("t4 ack_b1", 32'(ack), 32'd1);
        exp_q.push_back('{a: 7'd5, d: 9'h055, s: 1'b0});
        exp_regs[5] = 9'h055;
        xfer3("t4", 8'h34, 8'h0A, 8'h55, 1'b1);
        check_regs("t4");

        // 5: STOP midway through byte2, no commit
        start_cond();
        write_byte(8'h34, ack); check("t5 ack_addr", 32'(ack), 32'd1);
        write_byte(8'h08, ack); check("t5 ack_b1", 32'(ack), 32'd1);
        for (int i = 0; i < 4; i++) send_bit(i[0], r);
        stop_cond();
        check("t5 sda_oe", 32'(bus.o_sda_oe), 32'd0);
        check("t5 busy", 32'(bus.o_busy), 32'd0);
        check_regs("t5");

        // 6a: single-cycle SDA glitch while SCL high
`ifdef I2C_GLITCH_FILTER_EN
        exp_busy = 1'b0;
`else
        exp_busy = 1'b1;
`endif
        saw_busy = 1'b0;
        @(negedge clk); sda_m = 1'b0;
        @(negedge clk); sda_m = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            saw_busy = saw_busy | bus.o_busy;
        end
        check("t6 glitch_busy", 32'(saw_busy), 32'(exp_busy));
        qwait();

        // 6b: async reset while the responder is ACKing
        start_cond();
        for (int i = 7; i >= 0; i--) send_bit(logic'(8'h34 >> i), r);
        qwait(); sda_m = 1'b1;
        qwait(); scl_m = 1'b1;
        qwait();
        check("t6 oe_before_rst", 32'(bus.o_sda_oe), 32'd1);
        #3ns rst = 1'b1;
        #1ns check("t6 oe_at_rst", 32'(bus.o_sda_oe), 32'd0);
        defaults_to_model();
        @(negedge clk);
        check_regs("t6");
        check("t6 busy", 32'(bus.o_busy), 32'd0);
        sda_m = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        qwait();

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
